// File: rtl/pmu_ahb_master.sv
// -----------------------------------------------------------------------------
// pmu_ahb_master
// Single-outstanding AHB master that turns simple host register requests
// (index, read/write, data) into one AHB SINGLE word transfer to the PMU slave.
// It reports completion with a one-cycle done pulse plus an error code:
// 00 OK, 01 slave ERROR, 10 data-phase timeout, 11 index out of range.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i, we_i, idx_i,
//   wdata_i             host request, sampled only while ready_o = 1
//   ready_o             idle, a request can be accepted
//   done_o, err_o       one-cycle completion pulse and its failure flag
//   rdata_o, err_code_o read data and error code, held until next accept
//   hsel_o .. hwdata_o  AHB master outputs (all registered)
//   hready_i, hresp_i,
//   hrdata_i            AHB slave responses
// -----------------------------------------------------------------------------
module pmu_ahb_master #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8010_0000,
    parameter int                    N_REGS     = 47,
    parameter int                    IDX_WIDTH  = 6,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [IDX_WIDTH-1:0]  idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic                  hsel_o,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic                  hwrite_o,
    output logic [1:0]            htrans_o,
    output logic [2:0]            hsize_o,
    output logic [2:0]            hburst_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic                  hready_i,
    input  logic [1:0]            hresp_i,
    input  logic [DATA_WIDTH-1:0] hrdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_SLV_ERR = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] CODE_BAD_IDX = 2'b11;

    localparam logic [IDX_WIDTH:0] N_REGS_W  = N_REGS[IDX_WIDTH:0];
    localparam logic [7:0]         TIMEOUT_W = TIMEOUT[7:0];

    state_t                  state_r, state_s;
    logic                    ready_r, ready_s;
    logic                    done_r, done_s;
    logic                    err_r, err_s;
    logic [1:0]              err_code_r, err_code_s;
    logic [DATA_WIDTH-1:0]   rdata_r, rdata_s;
    logic                    hsel_r, hsel_s;
    logic [ADDR_WIDTH-1:0]   haddr_r, haddr_s;
    logic                    hwrite_r, hwrite_s;
    logic [1:0]              htrans_r, htrans_s;
    logic [DATA_WIDTH-1:0]   hwdata_r, hwdata_s;
    logic [7:0]              cnt_r, cnt_s;
    logic                    we_r, we_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
    logic                    bus_err_r, bus_err_s;

    logic                    idx_ok_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic                    bus_err_now_s;

    assign idx_ok_s      = ({1'b0, idx_i} < N_REGS_W);
    // Index is zero-extended before the shift; the add wraps at ADDR_WIDTH.
    assign addr_s        = BASE_ADDR + ({{(ADDR_WIDTH-IDX_WIDTH){1'b0}}, idx_i} << 2'd2);
    // Any non-OKAY response seen during the data phase makes the transfer fail,
    // including the first cycle of the two-cycle ERROR response.
    assign bus_err_now_s = bus_err_r | (hresp_i != 2'b00);

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= CODE_OK;
            rdata_r    <= {DATA_WIDTH{1'b0}};
            hsel_r     <= 1'b0;
            haddr_r    <= {ADDR_WIDTH{1'b0}};
            hwrite_r   <= 1'b0;
            htrans_r   <= TRANS_IDLE;
            hwdata_r   <= {DATA_WIDTH{1'b0}};
            cnt_r      <= 8'd0;
            we_r       <= 1'b0;
            wdata_r    <= {DATA_WIDTH{1'b0}};
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ready_r    <= ready_s;
            done_r     <= done_s;
            err_r      <= err_s;
            err_code_r <= err_code_s;
            rdata_r    <= rdata_s;
            hsel_r     <= hsel_s;
            haddr_r    <= haddr_s;
            hwrite_r   <= hwrite_s;
            htrans_r   <= htrans_s;
            hwdata_r   <= hwdata_s;
            cnt_r      <= cnt_s;
            we_r       <= we_s;
            wdata_r    <= wdata_s;
            bus_err_r  <= bus_err_s;
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        state_s    = state_r;
        ready_s    = ready_r;
        done_s     = 1'b0;
        err_s      = 1'b0;
        err_code_s = err_code_r;
        rdata_s    = rdata_r;
        hsel_s     = hsel_r;
        haddr_s    = haddr_r;
        hwrite_s   = hwrite_r;
        htrans_s   = htrans_r;
        hwdata_s   = hwdata_r;
        cnt_s      = cnt_r;
        we_s       = we_r;
        wdata_s    = wdata_r;
        bus_err_s  = bus_err_r;

        case (state_r)
            ST_IDLE: begin
                cnt_s     = 8'd0;
                bus_err_s = 1'b0;
                if (req_i) begin
                    ready_s    = 1'b0;
                    rdata_s    = {DATA_WIDTH{1'b0}};
                    err_code_s = CODE_OK;
                    hwdata_s   = {DATA_WIDTH{1'b0}};
                    if (idx_ok_s) begin
                        we_s     = we_i;
                        wdata_s  = wdata_i;
                        hsel_s   = 1'b1;
                        htrans_s = TRANS_NONSEQ;
                        hwrite_s = we_i;
                        haddr_s  = addr_s;
                        state_s  = ST_ADDR;
                    end else begin
                        // No bus access; RESP is entered with done still low,
                        // so the pulse lands one cycle later (in the slot an
                        // address phase would have used).
                        err_code_s = CODE_BAD_IDX;
                        state_s    = ST_RESP;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end

            ST_ADDR: begin
                if (hready_i) begin
                    hsel_s   = 1'b0;
                    htrans_s = TRANS_IDLE;
                    hwdata_s = we_r ? wdata_r : {DATA_WIDTH{1'b0}};
                    state_s  = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end

            ST_DATA: begin
                if (hready_i) begin
                    done_s  = 1'b1;
                    state_s = ST_RESP;
                    if (bus_err_now_s) begin
                        err_code_s = CODE_SLV_ERR;
                        err_s      = 1'b1;
                    end else begin
                        err_code_s = CODE_OK;
                        err_s      = 1'b0;
                        if (!we_r) begin
                            rdata_s = hrdata_i;
                        end else begin
                            rdata_s = {DATA_WIDTH{1'b0}};
                        end
                    end
                end else if (cnt_r == (TIMEOUT_W - 8'd1)) begin
                    // This edge is the TIMEOUT-th wait cycle: abort.
                    cnt_s      = cnt_r + 8'd1;
                    done_s     = 1'b1;
                    err_s      = 1'b1;
                    err_code_s = CODE_TIMEOUT;
                    state_s    = ST_RESP;
                end else begin
                    cnt_s     = cnt_r + 8'd1;
                    bus_err_s = bus_err_now_s;
                end
            end

            ST_RESP: begin
                if (done_r) begin
                    ready_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    done_s = 1'b1;
                    err_s  = (err_code_r != CODE_OK);
                end
            end

            default: begin
                ready_s  = 1'b1;
                hsel_s   = 1'b0;
                htrans_s = TRANS_IDLE;
                state_s  = ST_IDLE;
            end
        endcase
    end

    assign ready_o    = ready_r;
    assign done_o     = done_r;
    assign err_o      = err_r;
    assign err_code_o = err_code_r;
    assign rdata_o    = rdata_r;
    assign hsel_o     = hsel_r;
    assign haddr_o    = haddr_r;
    assign hwrite_o   = hwrite_r;
    assign htrans_o   = htrans_r;
    assign hwdata_o   = hwdata_r;
    assign hsize_o    = 3'b010;
    assign hburst_o   = 3'b000;

endmodule

// File: tb/tb_pmu_ahb_master.sv
// -----------------------------------------------------------------------------
// tb_pmu_ahb_master
// Randomized bench for pmu_ahb_master. A driver issues host requests and plays
// the AHB slave (wait states, ERROR, stuck hready). For every request the
// expected outcome (address, write data, response code, read data, completion
// cycle) is derived from the transaction plan and queued; two monitors pop and
// compare whenever the DUT opens an address phase or pulses done_o.
// -----------------------------------------------------------------------------
module tb_pmu_ahb_master;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          IW    = 6;
    localparam int          NREGS = 47;
    localparam int          TMO   = 255;
    localparam logic [31:0] BASE  = 32'h8010_0000;

    logic          clk;
    logic          rst;
    logic          req;
    logic          we;
    logic [IW-1:0] idx;
    logic [DW-1:0] wdata;
    logic          ready_o;
    logic          done_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic [1:0]    err_code_o;
    logic          hsel_o;
    logic [AW-1:0] haddr_o;
    logic          hwrite_o;
    logic [1:0]    htrans_o;
    logic [2:0]    hsize_o;
    logic [2:0]    hburst_o;
    logic [DW-1:0] hwdata_o;
    logic          hready;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] hwdata;
    } addr_exp_t;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] rdata;
        int          cyc;
    } resp_exp_t;

    addr_exp_t addr_q[$];
    resp_exp_t resp_q[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    pmu_ahb_master dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .we_i       (we),
        .idx_i      (idx),
        .wdata_i    (wdata),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .hsel_o     (hsel_o),
        .haddr_o    (haddr_o),
        .hwrite_o   (hwrite_o),
        .htrans_o   (htrans_o),
        .hsize_o    (hsize_o),
        .hburst_o   (hburst_o),
        .hwdata_o   (hwdata_o),
        .hready_i   (hready),
        .hresp_i    (hresp),
        .hrdata_i   (hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- address/data phase monitor ----------------
    logic [1:0]  prev_htrans = 2'b00;
    logic [31:0] pend_hwdata = 32'h0;
    addr_exp_t   ae;

    always @(negedge clk) begin
        if (rst) begin
            prev_htrans = 2'b00;
        end else begin
            if (htrans_o == 2'b10 && prev_htrans != 2'b10) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_nonseq", {62'd0, htrans_o}, 64'd0);
                end else begin
                    ae = addr_q.pop_front();
                    chk("haddr", haddr_o, ae.addr);
                    chk("hwrite", hwrite_o, ae.wr);
                    chk("hsel_addr", hsel_o, 1'b1);
                    pend_hwdata = ae.hwdata;
                end
            end
            if (htrans_o == 2'b00 && prev_htrans == 2'b10) begin
                chk("hwdata", hwdata_o, pend_hwdata);
                chk("hsel_data", hsel_o, 1'b0);
            end
            prev_htrans = htrans_o;
        end
    end

    // ---------------- completion monitor ----------------
    resp_exp_t   re;
    logic        post_done = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic [1:0]  last_code  = 2'b00;

    always @(negedge clk) begin
        if (rst) begin
            post_done = 1'b0;
        end else begin
            if (post_done) begin
                chk("ready_after_done", ready_o, 1'b1);
                chk("rdata_hold", rdata_o, last_rdata);
                chk("err_code_hold", err_code_o, last_code);
                post_done = 1'b0;
            end
            if (done_o === 1'b1) begin
                if (resp_q.size() == 0) begin
                    chk("spurious_done", done_o, 1'b0);
                end else begin
                    re = resp_q.pop_front();
                    chk("done_cycle", cyc, re.cyc);
                    chk("err_code", err_code_o, re.code);
                    chk("err", err_o, (re.code != 2'b00));
                    chk("rdata", rdata_o, re.rdata);
                    chk("htrans_at_done", htrans_o, 2'b00);
                    chk("hsel_at_done", hsel_o, 1'b0);
                    last_rdata = re.rdata;
                    last_code  = re.code;
                    post_done  = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        req = 1'b0;
        while (ready_o !== 1'b1 && guard < 600) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 600) chk("ready_wait_timeout", ready_o, 1'b1);
    endtask

    // One host transaction plus the slave behaviour for it.
    // a: address-phase wait cycles, w: data-phase wait cycles,
    // berr: slave answers ERROR (hresp=01 on every data-phase cycle).
    task automatic do_txn(input logic t_we, input logic [IW-1:0] t_idx, input logic [31:0] t_wd,
                          input int a, input int w, input logic berr, input logic [31:0] t_rd);
        int        acc;
        int        lat;
        addr_exp_t ax;
        resp_exp_t rx;
        wait_ready();
        req = 1'b1; we = t_we; idx = t_idx; wdata = t_wd;
        hready = 1'b1; hresp = 2'b00;
        @(posedge clk); #1;
        acc = cyc;
        req = 1'b0;
        // reference model
        if (int'(t_idx) >= NREGS) begin
            rx.code = 2'b11;
            lat     = 1;
        end else begin
            ax.addr   = BASE + 32'(int'(t_idx) * 4);
            ax.wr     = t_we;
            ax.hwdata = t_we ? t_wd : 32'h0;
            addr_q.push_back(ax);
            if (w >= TMO) begin
                rx.code = 2'b10;
                lat     = 1 + a + TMO;
            end else if (berr) begin
                rx.code = 2'b01;
                lat     = 2 + a + w;
            end else begin
                rx.code = 2'b00;
                lat     = 2 + a + w;
            end
        end
        rx.rdata = (rx.code == 2'b00 && !t_we) ? t_rd : 32'h0;
        rx.cyc   = acc + lat;
        resp_q.push_back(rx);
        if (int'(t_idx) < NREGS) begin
            for (int i = 0; i < a; i++) begin
                hready = 1'b0;
                req = 1'($urandom_range(0, 1)); idx = 6'($urandom_range(0, 63));
                @(posedge clk); #1;
            end
            hready = 1'b1; hresp = 2'b00;
            @(posedge clk); #1;
            for (int i = 0; i < w && i < TMO; i++) begin
                hready = 1'b0; hresp = berr ? 2'b01 : 2'b00; hrdata = $urandom;
                req = 1'($urandom_range(0, 1)); idx = 6'($urandom_range(0, 63));
                @(posedge clk); #1;
            end
            if (w < TMO) begin
                hready = 1'b1; hresp = berr ? 2'b01 : 2'b00; hrdata = t_rd;
                @(posedge clk); #1;
            end
            hready = 1'b1; hresp = 2'b00; hrdata = $urandom;
            req = 1'b0;
        end
    endtask

    initial begin
        #(500000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          r_we;
        logic [IW-1:0] r_idx;
        int            a, w, kind;
        logic          berr;
        rst = 1'b1; req = 1'b0; we = 1'b0; idx = '0; wdata = '0;
        hready = 1'b1; hresp = 2'b00; hrdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_err_code", err_code_o, 2'b00);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_hsel", hsel_o, 1'b0);
        chk("rst_htrans", htrans_o, 2'b00);
        chk("rst_hwrite", hwrite_o, 1'b0);
        chk("rst_haddr", haddr_o, 32'h0);
        chk("rst_hwdata", hwdata_o, 32'h0);
        chk("hsize", hsize_o, 3'b010);
        chk("hburst", hburst_o, 3'b000);
        rst = 1'b0;

        // directed cases
        do_txn(1'b1, 6'd0,  32'h0000_0002, 0, 0,   1'b0, 32'h1111_1111);
        do_txn(1'b0, 6'd43, 32'h5555_5555, 0, 3,   1'b0, 32'hcafe_cafe);
        do_txn(1'b0, 6'd7,  32'h0,         0, 1,   1'b1, 32'h7777_7777);
        do_txn(1'b1, 6'd12, 32'hdead_beef, 0, TMO, 1'b0, 32'h0);
        do_txn(1'b1, 6'd47, 32'h1234_0000, 0, 0,   1'b0, 32'h0);
        do_txn(1'b0, 6'd46, 32'h0,         1, 0,   1'b0, 32'h0bad_f00d);

        // reset while the data phase is stalled
        wait_ready();
        req = 1'b1; we = 1'b0; idx = 6'd5; wdata = 32'h0;
        hready = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        addr_q.push_back('{addr: BASE + 32'd20, wr: 1'b0, hwdata: 32'h0});
        @(posedge clk); #1;
        hready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_hsel", hsel_o, 1'b0);
        chk("midrst_htrans", htrans_o, 2'b00);
        chk("midrst_ready", ready_o, 1'b1);
        chk("midrst_done", done_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; hready = 1'b1;
        do_txn(1'b1, 6'd20, 32'h1234_5678, 0, 0, 1'b0, 32'h0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_idx = 6'($urandom_range(0, 63));
            a     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            kind  = $urandom_range(0, 9);
            if (kind == 0) begin
                berr = 1'b1; w = $urandom_range(1, 3);
            end else begin
                berr = 1'b0; w = (kind < 5) ? 0 : $urandom_range(1, 5);
            end
            do_txn(r_we, r_idx, $urandom, a, w, berr, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        wait_ready();
        repeat (4) @(posedge clk);
        #1;
        chk("resp_queue_drained", resp_q.size(), 0);
        chk("addr_queue_drained", addr_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
